// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// vga_pkg : 640x480@60 timing constants, test-pattern encodings and pixel rule
// Rev 1.0
// ============================================================================
package vga_pkg;

  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  typedef enum logic [1:0] {
    PAT_BLACK  = 2'd0,
    PAT_WHITE  = 2'd1,
    PAT_CHECK  = 2'd2,
    PAT_BORDER = 2'd3
  } pattern_e;

  // x_last/y_last are the last visible column and row, which the border outlines.
  function automatic logic pattern_pixel(
    input pattern_e   pat,
    input logic [9:0] x,
    input logic [9:0] y,
    input logic [9:0] x_last,
    input logic [9:0] y_last
  );
    logic bit_v;
    case (pat)
      PAT_WHITE:  bit_v = 1'b1;
      PAT_CHECK:  bit_v = x[5] ^ y[5];
      PAT_BORDER: bit_v = (x == 10'd0) || (x == x_last) || (y == 10'd0) || (y == y_last);
      default:    bit_v = 1'b0;
    endcase
    return bit_v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_pix_tick.sv
`default_nettype none
// ============================================================================
// vga_pix_tick : divides the system clock down to a one-clk pixel-rate tick
// Rev 1.0
// ============================================================================
module vga_pix_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  // A 1-bit divider that never leaves 0 keeps the tick high when CLK_DIV is 1.
  localparam int           W        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] DIV_LAST = W'(CLK_DIV - 1);

  logic [W-1:0] div_q;
  logic [W-1:0] div_d;

  assign tick_o = (div_q == DIV_LAST);

  always_comb begin
    div_d = tick_o ? '0 : div_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// vga_sync_gen : VGA sync/visible timing, pixel coordinates and test pattern
// Rev 1.0
// ============================================================================
module vga_sync_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_VIS    = vga_pkg::H_VIS,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_VIS    = vga_pkg::V_VIS,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] pattern_sel,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       color_out,
  output logic       frame_start
);

  import vga_pkg::*;

  localparam int         H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int         V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] X_VIS    = 10'(H_VIS);
  localparam logic [9:0] Y_VIS    = 10'(V_VIS);
  localparam logic [9:0] X_EDGE   = 10'(H_VIS - 1);
  localparam logic [9:0] Y_EDGE   = 10'(V_VIS - 1);

  logic       tick;
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  pattern_e   pat_q, pat_d;
  logic       started_q, started_d;

  logic       hsync_q, vsync_q, video_on_q, color_q, frame_start_q;
  logic [9:0] pix_x_q, pix_y_q;

  logic       at_origin;
  logic       hs_act;
  logic       vs_act;
  logic       vis;
  pattern_e   pat_eff;

  vga_pix_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_o (tick)
  );

  assign at_origin = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
  assign hs_act    = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
  assign vs_act    = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
  assign vis       = (h_cnt_q < X_VIS) && (v_cnt_q < Y_VIS);

  // Pixel (0,0) is decoded before the frame's latch edge, so it takes the
  // incoming selection directly; the rest of the frame uses the latched copy.
  assign pat_eff   = at_origin ? pattern_e'(pattern_sel) : pat_q;

  always_comb begin
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    pat_d     = pat_q;
    started_d = started_q;
    if (tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = 10'd0;
        v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
      // The first advance away from (0,0) arms frame_start, so the frame
      // entered straight out of reset never pulses.
      if (at_origin) begin
        pat_d = pattern_e'(pattern_sel);
      end else begin
        started_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q       <= 10'd0;
      v_cnt_q       <= 10'd0;
      pat_q         <= PAT_BLACK;
      started_q     <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      color_q       <= 1'b0;
      frame_start_q <= 1'b0;
      pix_x_q       <= 10'd0;
      pix_y_q       <= 10'd0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      pat_q         <= pat_d;
      started_q     <= started_d;
      hsync_q       <= hs_act ? SYNC_POL : ~SYNC_POL;
      vsync_q       <= vs_act ? SYNC_POL : ~SYNC_POL;
      video_on_q    <= vis;
      color_q       <= vis & pattern_pixel(pat_eff, h_cnt_q, v_cnt_q, X_EDGE, Y_EDGE);
      frame_start_q <= tick & at_origin & started_q;
      pix_x_q       <= h_cnt_q;
      pix_y_q       <= v_cnt_q;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign color_out   = color_q;
  assign frame_start = frame_start_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// tb_vga_sync_gen : four generator instances checked every clk against a
// frame-arithmetic reference model, plus timing measurements and async resets
// Rev 1.0
// ============================================================================
module tb_vga_sync_gen;

  // Instance 0/1: full 640x480 timing at CLK_DIV 2 and 1.
  // Instance 2/3: shrunken timing so whole frames fit in the run; 3 uses active-high sync.
  localparam int N = 4;
  localparam int P_D   [N] = '{2, 1, 2, 3};
  localparam int P_HV  [N] = '{640, 640, 80, 80};
  localparam int P_HF  [N] = '{16, 16, 4, 4};
  localparam int P_HS  [N] = '{96, 96, 8, 8};
  localparam int P_HB  [N] = '{48, 48, 6, 6};
  localparam int P_VV  [N] = '{480, 480, 70, 70};
  localparam int P_VF  [N] = '{10, 10, 2, 2};
  localparam int P_VS  [N] = '{2, 2, 2, 2};
  localparam int P_VB  [N] = '{33, 33, 3, 3};
  localparam bit P_POL [N] = '{1'b0, 1'b0, 1'b0, 1'b1};

  logic            clk = 1'b0;
  logic [N-1:0]    rst_n = '0;
  logic [N-1:0][1:0] psel = '0;
  logic [N-1:0]    hs, vs, von, col, fs;
  logic [N-1:0][9:0] px, py;

  int k [N] = '{0, 0, 0, 0};
  logic [1:0] mpat [N] = '{2'd0, 2'd0, 2'd0, 2'd0};

  int errors = 0;
  int checks = 0;

  int act_h_k [N] = '{0, 0, 0, 0};
  int act_h_w [N] = '{0, 0, 0, 0};
  int h_done  [N] = '{0, 0, 0, 0};
  int act_v_k [N] = '{0, 0, 0, 0};
  int act_v_w [N] = '{0, 0, 0, 0};
  int v_done  [N] = '{0, 0, 0, 0};
  int fs_k1   [N] = '{0, 0, 0, 0};
  int fs_k2   [N] = '{0, 0, 0, 0};
  int von_l0  [N] = '{0, 0, 0, 0};
  logic [24:0] obs;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    vga_sync_gen #(
      .CLK_DIV  (P_D[g]),
      .H_VIS    (P_HV[g]),
      .H_FP     (P_HF[g]),
      .H_SYNC   (P_HS[g]),
      .H_BP     (P_HB[g]),
      .V_VIS    (P_VV[g]),
      .V_FP     (P_VF[g]),
      .V_SYNC   (P_VS[g]),
      .V_BP     (P_VB[g]),
      .SYNC_POL (P_POL[g])
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n[g]),
      .pattern_sel (psel[g]),
      .hsync       (hs[g]),
      .vsync       (vs[g]),
      .video_on    (von[g]),
      .pix_x       (px[g]),
      .pix_y       (py[g]),
      .color_out   (col[g]),
      .frame_start (fs[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int h_total(input int i);
    return P_HV[i] + P_HF[i] + P_HS[i] + P_HB[i];
  endfunction

  function automatic int frame_len(input int i);
    return h_total(i) * (P_VV[i] + P_VF[i] + P_VS[i] + P_VB[i]);
  endfunction

  function automatic logic [24:0] obs_vec(input int i);
    return {hs[i], vs[i], von[i], col[i], fs[i], px[i], py[i]};
  endfunction

  function automatic logic [24:0] rst_vec(input int i);
    return {~P_POL[i], ~P_POL[i], 23'd0};
  endfunction

  // Expected outputs seen after the kk-th clk since reset release: the pixel
  // index is the number of completed pixel periods before that edge.
  function automatic logic [24:0] model(input int i, input int kk, input logic [1:0] pat);
    int   d, hv, vv, ht, fl, t, pos, x, y;
    logic h_s, v_s, vo, c, f;
    d   = P_D[i];
    hv  = P_HV[i];
    vv  = P_VV[i];
    ht  = h_total(i);
    fl  = frame_len(i);
    t   = (kk - 1) / d;
    pos = t % fl;
    x   = pos % ht;
    y   = pos / ht;
    h_s = ((x >= hv + P_HF[i]) && (x < hv + P_HF[i] + P_HS[i])) ? P_POL[i] : ~P_POL[i];
    v_s = ((y >= vv + P_VF[i]) && (y < vv + P_VF[i] + P_VS[i])) ? P_POL[i] : ~P_POL[i];
    vo  = (x < hv) && (y < vv);
    case (pat)
      2'd0:    c = 1'b0;
      2'd1:    c = 1'b1;
      2'd2:    c = ((x / 32) % 2) != ((y / 32) % 2);
      default: c = (x == 0) || (x == hv - 1) || (y == 0) || (y == vv - 1);
    endcase
    c = c & vo;
    f = (((kk - 1) % d) == d - 1) && (pos == 0) && (t >= fl);
    return {h_s, v_s, vo, c, f, 10'(x), 10'(y)};
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      k[i] <= rst_n[i] ? k[i] + 1 : 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      obs = obs_vec(i);
      if (!rst_n[i] || k[i] == 0) begin
        check($sformatf("reset_out%0d", i), 32'(obs), 32'(rst_vec(i)));
        act_h_k[i] = 0; act_h_w[i] = 0; h_done[i] = 0;
        act_v_k[i] = 0; act_v_w[i] = 0; v_done[i] = 0;
        fs_k1[i] = 0; fs_k2[i] = 0; von_l0[i] = 0;
      end else begin
        if (((k[i] - 1) % P_D[i]) == 0 && (((k[i] - 1) / P_D[i]) % frame_len(i)) == 0)
          mpat[i] = psel[i];
        check($sformatf("outs%0d", i), 32'(obs), 32'(model(i, k[i], mpat[i])));
        if (hs[i] == P_POL[i]) begin
          if (act_h_k[i] == 0) act_h_k[i] = k[i];
          if (h_done[i] == 0) act_h_w[i]++;
        end else if (act_h_k[i] != 0) begin
          h_done[i] = 1;
        end
        if (vs[i] == P_POL[i]) begin
          if (act_v_k[i] == 0) act_v_k[i] = k[i];
          if (v_done[i] == 0) act_v_w[i]++;
        end else if (act_v_k[i] != 0) begin
          v_done[i] = 1;
        end
        if (fs[i]) begin
          if (fs_k1[i] == 0) fs_k1[i] = k[i];
          else if (fs_k2[i] == 0) fs_k2[i] = k[i];
        end
        if (von[i] && k[i] <= h_total(i) * P_D[i]) von_l0[i]++;
      end
    end
  end

  // Random pattern changes, kept off the clks where the counters sit at (0,0).
  initial begin
    forever begin
      @(negedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (rst_n[i] && $urandom_range(0, 3999) == 0 &&
            ((k[i] / P_D[i]) % frame_len(i)) != 0)
          psel[i] = 2'($urandom_range(0, 3));
      end
    end
  end

  initial begin
    psel[0] = 2'd2; psel[1] = 2'd3; psel[2] = 2'd2; psel[3] = 2'd3;
    repeat (3) @(negedge clk);
    #1 rst_n = '1;

    repeat (2000) @(negedge clk);
    #2;
    check("d0_hs_start", 32'(act_h_k[0]), 32'd1313);
    check("d0_hs_width", 32'(act_h_w[0]), 32'd192);
    check("d1_hs_start", 32'(act_h_k[1]), 32'd657);
    check("d1_hs_width", 32'(act_h_w[1]), 32'd96);

    @(negedge clk);
    #3 rst_n[0] = 1'b0;
    #1 check("d0_async_rst", 32'(obs_vec(0)), 32'(rst_vec(0)));
    repeat (3) @(negedge clk);
    #1 rst_n[0] = 1'b1;
    repeat (1700) @(negedge clk);
    #2;
    check("d0_hs_start_rerun", 32'(act_h_k[0]), 32'd1313);
    check("d0_hs_width_rerun", 32'(act_h_w[0]), 32'd192);

    repeat (16300) @(negedge clk);
    #3 rst_n[2] = 1'b0;
    #1 check("d2_async_rst", 32'(obs_vec(2)), 32'(rst_vec(2)));
    repeat (3) @(negedge clk);
    #1 rst_n[2] = 1'b1;

    repeat (31000) @(negedge clk);
    #2;
    check("d2_hs_width", 32'(act_h_w[2]), 32'd16);
    check("d2_vs_start", 32'(act_v_k[2]), 32'(72 * 98 * 2 + 1));
    check("d2_vs_width", 32'(act_v_w[2]), 32'd392);
    check("d2_line0_video", 32'(von_l0[2]), 32'd160);
    check("d2_fs_first", 32'(fs_k1[2]), 32'd15094);
    check("d2_fs_period", 32'(fs_k2[2] - fs_k1[2]), 32'd15092);
    check("d3_hs_width", 32'(act_h_w[3]), 32'd24);
    check("d3_vs_width", 32'(act_v_w[3]), 32'd588);
    check("d3_line0_video", 32'(von_l0[3]), 32'd240);
    check("d3_fs_first", 32'(fs_k1[3]), 32'd22641);
    check("d3_fs_period", 32'(fs_k2[3] - fs_k1[3]), 32'd22638);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
